// File: rtl/exu_div_pkg.sv
// Shared widths and FSM state type for the integer divide unit.
package exu_div_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned REG_FILE_ADDR_WIDTH = 5;
    localparam int unsigned DIV_CNT_WIDTH       = 6;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_t;

endpackage

// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a one-cycle
// fast path for divide-by-zero and signed overflow.
module exu_div
    import exu_div_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           div_issue,
    input  logic [XLEN-1:0]                div_rs1_data,
    input  logic [XLEN-1:0]                div_rs2_data,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] div_rd_addr,
    input  logic                           div_unsign,
    input  logic                           div_rem,
    input  logic                           pipe_flush,
    output logic                           exu_div_busy,
    output logic [XLEN-1:0]                div_wb_data,
    output logic [REG_FILE_ADDR_WIDTH-1:0] div_wb_rd_addr,
    output logic                           div_wb_rd_wr_en
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t                     state_q, state_d;
    logic [XLEN-1:0]                quo_q, quo_d;
    logic [XLEN-1:0]                rem_q, rem_d;
    logic [XLEN-1:0]                dvs_q, dvs_d;
    logic [XLEN-1:0]                res_q, res_d;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DIV_CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                           rem_sel_q, rem_sel_d;
    logic                           quo_neg_q, quo_neg_d;
    logic                           rem_neg_q, rem_neg_d;

    logic            accept, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   shifted, diff;

    assign accept   = ((state_q == StIdle) || (state_q == StDone)) && div_issue && !pipe_flush;
    assign a_neg    = !div_unsign && div_rs1_data[XLEN-1];
    assign b_neg    = !div_unsign && div_rs2_data[XLEN-1];
    assign a_abs    = a_neg ? -div_rs1_data : div_rs1_data;
    assign b_abs    = b_neg ? -div_rs2_data : div_rs2_data;
    assign div_zero = (div_rs2_data == '0);
    assign overflow = !div_unsign && (div_rs1_data == MinNeg) && (div_rs2_data == '1);

    // Partial remainder shifts in the next dividend bit from the top of quo_q.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    rd_d      = div_rd_addr;
                    rem_sel_d = div_rem;
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    if (div_zero) begin
                        res_d   = div_rem ? div_rs1_data : '1;
                        state_d = StDone;
                    end else if (overflow) begin
                        res_d   = div_rem ? '0 : MinNeg;
                        state_d = StDone;
                    end else begin
                        quo_d   = a_abs;
                        rem_d   = '0;
                        dvs_d   = b_abs;
                        cnt_d   = DIV_CNT_WIDTH'(XLEN - 1);
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (diff[XLEN]) begin
                    rem_d = shifted[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end
                cnt_d = cnt_q - DIV_CNT_WIDTH'(1);
                if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (rem_sel_q) begin
                    res_d = rem_neg_q ? -rem_q : rem_q;
                end else begin
                    res_d = quo_neg_q ? -quo_q : quo_q;
                end
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    // Outputs are forced low combinationally so they read zero for the whole reset cycle.
    assign exu_div_busy    = !rst && ((state_q == StCalc) || (state_q == StFix));
    assign div_wb_rd_wr_en = !rst && (state_q == StDone) && (rd_q != '0);
    assign div_wb_data     = rst ? '0 : res_q;
    assign div_wb_rd_addr  = rst ? '0 : rd_q;

endmodule

// File: tb/tb_exu_div.sv
// Randomised scoreboard bench for exu_div: a driver pushes expected writebacks,
// a negedge monitor checks strobes, timing, busy and reset values.
module tb_exu_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        div_issue = 1'b0;
    logic [31:0] div_rs1_data = '0;
    logic [31:0] div_rs2_data = '0;
    logic [4:0]  div_rd_addr = '0;
    logic        div_unsign = 1'b0;
    logic        div_rem = 1'b0;
    logic        pipe_flush = 1'b0;
    logic        exu_div_busy;
    logic [31:0] div_wb_data;
    logic [4:0]  div_wb_rd_addr;
    logic        div_wb_rd_wr_en;

    exu_div u_dut (
        .clk             (clk),
        .rst             (rst),
        .div_issue       (div_issue),
        .div_rs1_data    (div_rs1_data),
        .div_rs2_data    (div_rs2_data),
        .div_rd_addr     (div_rd_addr),
        .div_unsign      (div_unsign),
        .div_rem         (div_rem),
        .pipe_flush      (pipe_flush),
        .exu_div_busy    (exu_div_busy),
        .div_wb_data     (div_wb_data),
        .div_wb_rd_addr  (div_wb_rd_addr),
        .div_wb_rd_wr_en (div_wb_rd_wr_en)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   mon_en = 1'b0;

    // RISC-V M-extension divide semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic uns, input logic rem);
        int sa, sb_v;
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (uns) return rem ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        sa   = $signed(a);
        sb_v = $signed(b);
        return rem ? 32'(sa % sb_v) : 32'(sa / sb_v);
    endfunction

    function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic uns);
        if (b == 32'd0) return 1;
        if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one issue in the current cycle and records what should come back.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                            input logic uns, input logic rem, input logic flush,
                            output int lat);
        int t;
        exp_t e;
        t            = cyc;
        lat          = latency(a, b, uns);
        div_issue    = 1'b1;
        div_rs1_data = a;
        div_rs2_data = b;
        div_rd_addr  = rd;
        div_unsign   = uns;
        div_rem      = rem;
        pipe_flush   = flush;
        if (!flush) begin
            if (rd != 5'd0) begin
                e.data = ref_div(a, b, uns, rem);
                e.addr = rd;
                e.cyc  = t + lat;
                sb.push_back(e);
            end
            if (lat > 1) begin
                busy_lo = t + 1;
                busy_hi = t + 33;
            end
        end
        next_cycle();
        div_issue  = 1'b0;
        pipe_flush = 1'b0;
    endtask

    task automatic wait_done(input int lat);
        for (int k = 1; k < lat; k++) next_cycle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst) begin
            checks++;
            if ({exu_div_busy, div_wb_rd_wr_en, div_wb_data, div_wb_rd_addr} != '0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d busy=%b wr_en=%b data=%h addr=%0d required all 0",
                         cyc, exu_div_busy, div_wb_rd_wr_en, div_wb_data, div_wb_rd_addr);
            end
            sb.delete();
        end else if (mon_en) begin
            exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
            checks++;
            if (exu_div_busy !== exp_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, exu_div_busy, exp_busy);
            end
            if (div_wb_rd_wr_en === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strobe cyc=%0d data=%h addr=%0d want no strobe",
                             cyc, div_wb_data, div_wb_rd_addr);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc) begin
                        failures++;
                        $display("FAIL wb_timing got cyc=%0d want cyc=%0d", cyc, e.cyc);
                    end
                    checks += 2;
                    if (div_wb_data !== e.data) begin
                        failures++;
                        $display("FAIL wb_data cyc=%0d got=%h want=%h", cyc, div_wb_data, e.data);
                    end
                    if (div_wb_rd_addr !== e.addr) begin
                        failures++;
                        $display("FAIL wb_addr cyc=%0d got=%0d want=%0d",
                                 cyc, div_wb_rd_addr, e.addr);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                failures++;
                e = sb.pop_front();
                $display("FAIL missing_strobe cyc=%0d want data=%h addr=%0d at cyc=%0d",
                         cyc, e.data, e.addr, e.cyc);
            end
        end
    end

    initial begin
        int lat, lat2, t0;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        uns, rem;
        int          sel;

        repeat (3) next_cycle();
        rst    = 1'b0;
        mon_en = 1'b1;
        next_cycle();

        // Directed cases.
        start_op(32'd100, 32'd7, 5'd5, 1'b1, 1'b0, 1'b0, lat); wait_done(lat);
        start_op(32'd100, 32'd7, 5'd5, 1'b1, 1'b1, 1'b0, lat); wait_done(lat);
        start_op(-32'sd7, 32'd2, 5'd9, 1'b0, 1'b0, 1'b0, lat); wait_done(lat);
        start_op(-32'sd7, 32'd2, 5'd9, 1'b0, 1'b1, 1'b0, lat); wait_done(lat);
        next_cycle();
        start_op(32'd5, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, lat); wait_done(lat);
        start_op(32'd5, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, lat); wait_done(lat);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b0, 1'b0, lat); wait_done(lat);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b0, 1'b1, 1'b0, lat); wait_done(lat);
        next_cycle();

        // Flushed issue is dropped.
        start_op(32'd50, 32'd5, 5'd4, 1'b1, 1'b0, 1'b1, lat);
        next_cycle();

        // Reset in the middle of an op, then a fresh op two cycles later.
        t0 = cyc;
        start_op(32'd1000, 32'd3, 5'd6, 1'b1, 1'b0, 1'b0, lat);
        while (cyc < t0 + 10) next_cycle();
        rst     = 1'b1;
        busy_hi = t0 + 9;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        start_op(32'd1000, 32'd3, 5'd6, 1'b1, 1'b1, 1'b0, lat); wait_done(lat);

        // Back-to-back: second op with rd=0 issued in the first op's DONE cycle.
        start_op(32'd77, 32'd8, 5'd2, 1'b1, 1'b0, 1'b0, lat); wait_done(lat);
        start_op(32'd77, 32'd8, 5'd0, 1'b1, 1'b0, 1'b0, lat); wait_done(lat);
        next_cycle();

        // Random ops, some back-to-back, some with a protocol-violating issue mid-flight.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            uns = 1'($urandom_range(0, 1));
            rem = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin
                a   = 32'h8000_0000;
                b   = 32'hFFFF_FFFF;
                uns = 1'b0;
            end
            if (sel == 2) a = $urandom_range(0, 200);
            repeat ($urandom_range(0, 1)) next_cycle();
            if ($urandom_range(0, 7) == 0) begin
                start_op(a, b, rd, uns, rem, 1'b1, lat);
            end else begin
                start_op(a, b, rd, uns, rem, 1'b0, lat);
                lat2 = (lat > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
                for (int k = 1; k < lat; k++) begin
                    if (k == lat2) begin
                        div_issue    = 1'b1;
                        div_rs1_data = $urandom;
                        div_rs2_data = $urandom;
                        div_rd_addr  = 5'($urandom_range(1, 31));
                        div_unsign   = 1'($urandom_range(0, 1));
                        div_rem      = 1'($urandom_range(0, 1));
                    end
                    next_cycle();
                    div_issue = 1'b0;
                end
            end
        end

        repeat (40) next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
